// File: rtl/da2_dac_tx_pkg.sv
// Shared constants and types for the Pmod DA2 dual-DAC serial transmitter.
package da2_dac_tx_pkg;

  localparam int         FRAME_BITS = 16;
  localparam int         DATA_BITS  = 12;
  localparam logic [1:0] PD_NORMAL  = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  // DAC121S101 input word: two don't-care zeros, power-down mode, sample.
  typedef struct packed {
    logic [1:0]           rsvd;
    logic [1:0]           pd;
    logic [DATA_BITS-1:0] data;
  } frame_t;

  function automatic frame_t make_frame(input logic [1:0] pd, input logic [DATA_BITS-1:0] data);
    frame_t f;
    f.rsvd = 2'b00;
    f.pd   = pd;
    f.data = data;
    return f;
  endfunction

endpackage

// File: rtl/da2_dac_tx_shifter.sv
// One-channel frame shift register; the MSB flop drives the DAC data pin directly.
// Loads in one cycle; shifts one bit per shift strobe, zero-filling so DIN idles low.
module dac_chan_shifter
  import da2_dac_tx_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [FRAME_BITS-1:0] word,
  output logic                  dout
);

  logic [FRAME_BITS-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= word;
    end else if (shift) begin
      sr <= {sr[FRAME_BITS-2:0], 1'b0};
    end
  end

  assign dout = sr[FRAME_BITS-1];

endmodule

// File: rtl/da2_dac_tx.sv
// Pmod DA2 transmitter: one sample pair per valid/ready handshake, sent as a SYNC-framed 16-bit word.
// Frame starts on the accept edge; in_ready is high only in IDLE, so frame period is 34*CLK_DIV+1 cycles.
module da2_dac_tx
  import da2_dac_tx_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] data_a,
  input  logic [DATA_BITS-1:0] data_b,
  input  logic [1:0]           pd,
  output logic                 SYNC,
  output logic                 SCLK,
  output logic                 DINA,
  output logic                 DINB,
  output logic                 busy
);

  localparam int               DIV_W    = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       bit_cnt;
  logic             div_last;
  logic             accept;
  logic             load;
  logic             shift;
  frame_t           word_a, word_b;

  assign in_ready = (state == IDLE) & ~RST;
  assign accept   = in_valid & in_ready;
  assign div_last = (div_cnt == DIV_LAST);
  assign word_a   = make_frame(pd, data_a);
  assign word_b   = make_frame(pd, data_b);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A shift at the end of bit 0 also empties the shifters, so DIN* drops to 0 in GAP.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (div_last && !SCLK) begin
          shift = 1'b1;
          if (bit_cnt == 4'd0) begin
            state_nxt = GAP;
          end
        end
      end
      GAP: begin
        if (div_last && bit_cnt == 4'd0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // In GAP, bit_cnt is reused to count the two half-bit periods of SYNC-high time.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      SYNC    <= 1'b1;
      SCLK    <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          div_cnt <= '0;
          if (load) begin
            bit_cnt <= 4'(FRAME_BITS - 1);
            SYNC    <= 1'b0;
            SCLK    <= 1'b1;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          if (div_last) begin
            div_cnt <= '0;
            if (SCLK) begin
              SCLK <= 1'b0;
            end else if (bit_cnt == 4'd0) begin
              SYNC    <= 1'b1;
              SCLK    <= 1'b1;
              bit_cnt <= 4'd1;
            end else begin
              SCLK    <= 1'b1;
              bit_cnt <= bit_cnt - 4'd1;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        GAP: begin
          if (div_last) begin
            div_cnt <= '0;
            if (bit_cnt == 4'd0) begin
              busy <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt - 4'd1;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: begin
          div_cnt <= '0;
        end
      endcase
    end
  end

  dac_chan_shifter u_shift_a (
    .clk   (CLK),
    .rst   (RST),
    .load  (load),
    .shift (shift),
    .word  (word_a),
    .dout  (DINA)
  );

  dac_chan_shifter u_shift_b (
    .clk   (CLK),
    .rst   (RST),
    .load  (load),
    .shift (shift),
    .word  (word_b),
    .dout  (DINB)
  );

endmodule

// File: tb/tb_da2_dac_tx.sv
// Bench for da2_dac_tx: a CLK_DIV=2 and a CLK_DIV=1 instance, frames decoded on SCLK falling edges.
module tb_da2_dac_tx;
  import da2_dac_tx_pkg::*;

  logic        CLK = 1'b0;
  logic        rst2, rst1, valid2, valid1;
  logic [11:0] data_a, data_b;
  logic [1:0]  pd;
  logic        rdy2, sync2, sclk2, dina2, dinb2, busy2;
  logic        rdy1, sync1, sclk1, dina1, dinb1, busy1;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  da2_dac_tx #(.CLK_DIV(2)) dut (
    .CLK(CLK), .RST(rst2), .in_valid(valid2), .in_ready(rdy2),
    .data_a(data_a), .data_b(data_b), .pd(pd),
    .SYNC(sync2), .SCLK(sclk2), .DINA(dina2), .DINB(dinb2), .busy(busy2)
  );

  da2_dac_tx #(.CLK_DIV(1)) dut1 (
    .CLK(CLK), .RST(rst1), .in_valid(valid1), .in_ready(rdy1),
    .data_a(data_a), .data_b(data_b), .pd(pd),
    .SYNC(sync1), .SCLK(sclk1), .DINA(dina1), .DINB(dinb1), .busy(busy1)
  );

  // Monitor view of whichever instance is under test (sel=1 selects the CLK_DIV=1 build).
  bit   sel = 1'b0;
  logic m_rdy, m_sync, m_sclk, m_dina, m_dinb, m_busy;
  always_comb begin
    m_rdy  = sel ? rdy1  : rdy2;
    m_sync = sel ? sync1 : sync2;
    m_sclk = sel ? sclk1 : sclk2;
    m_dina = sel ? dina1 : dina2;
    m_dinb = sel ? dinb1 : dinb2;
    m_busy = sel ? busy1 : busy2;
  end

  // Reference: the DAC word is two zero bits, the power-down bits, then the sample.
  function automatic logic [15:0] exp_word(input logic [1:0] p, input logic [11:0] d);
    return {2'b00, p, d};
  endfunction

  logic [15:0] cap_a, cap_b;
  int          cap_fall, cap_low, cap_chg, cap_t, cap_gap;
  logic        cap_rdy;

  logic [11:0] q_a[3], q_b[3];
  logic [15:0] r_a[3], r_b[3];
  int          r_t[3], r_gap[3], r_low[3], r_chg[3], r_fall[3];

  task automatic set_valid(input logic v);
    if (sel) valid1 = v;
    else     valid2 = v;
  endtask

  task automatic send(input logic [11:0] a, input logic [11:0] b, input logic [1:0] p);
    int w = 0;
    @(negedge CLK);
    data_a = a; data_b = b; pd = p;
    set_valid(1'b1);
    while (!m_rdy && w < 300) begin
      @(negedge CLK);
      w++;
    end
    checks++;
    if (!m_rdy) begin
      failures++;
      $display("FAIL send_ready_timeout in_ready=%0b want=1", m_rdy);
    end
    @(posedge CLK);
    #1;
    set_valid(1'b0);
  endtask

  // Waits for SYNC to fall, then decodes one frame and measures its SYNC-low and GAP lengths.
  task automatic capture();
    int   w = 0;
    logic prev;
    cap_a = '0; cap_b = '0; cap_fall = 0; cap_low = 0; cap_chg = 0; cap_gap = 0; cap_t = 0;
    @(negedge CLK);
    while (m_sync && w < 300) begin
      @(negedge CLK);
      w++;
    end
    checks++;
    if (m_sync) begin
      failures++;
      $display("FAIL frame_start_timeout SYNC=%0b want=0", m_sync);
      return;
    end
    cap_t = cyc;
    prev  = 1'b1;
    while (!m_sync && cap_low < 300) begin
      cap_low++;
      if (m_sclk != prev) cap_chg++;
      if (prev && !m_sclk) begin
        cap_fall++;
        cap_a = {cap_a[14:0], m_dina};
        cap_b = {cap_b[14:0], m_dinb};
      end
      prev = m_sclk;
      @(negedge CLK);
    end
    while (m_sync && m_busy && cap_gap < 300) begin
      cap_gap++;
      @(negedge CLK);
    end
    cap_rdy = m_rdy;
  endtask

  // Holds in_valid high across n frames, presenting the next pair right after each accept.
  task automatic run_b2b(input int n);
    @(negedge CLK);
    fork
      begin
        int w;
        for (int k = 0; k < n; k++) begin
          data_a = q_a[k]; data_b = q_b[k]; pd = PD_NORMAL;
          set_valid(1'b1);
          w = 0;
          while (!m_rdy && w < 300) begin
            @(negedge CLK);
            w++;
          end
          @(posedge CLK);
          #1;
        end
        set_valid(1'b0);
      end
      begin
        for (int k = 0; k < n; k++) begin
          capture();
          r_a[k] = cap_a; r_b[k] = cap_b; r_t[k] = cap_t; r_gap[k] = cap_gap;
          r_low[k] = cap_low; r_chg[k] = cap_chg; r_fall[k] = cap_fall;
        end
      end
    join
  endtask

  task automatic test_reset();
    rst2 = 1'b1; rst1 = 1'b1;
    repeat (5) @(negedge CLK);
    checks++; if (sync2 !== 1'b1) begin failures++; $display("FAIL reset_sync got=%b want=1", sync2); end
    checks++; if (sclk2 !== 1'b1) begin failures++; $display("FAIL reset_sclk got=%b want=1", sclk2); end
    checks++; if (dina2 !== 1'b0) begin failures++; $display("FAIL reset_dina got=%b want=0", dina2); end
    checks++; if (dinb2 !== 1'b0) begin failures++; $display("FAIL reset_dinb got=%b want=0", dinb2); end
    checks++; if (rdy2 !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b want=0", rdy2); end
    checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy2); end
    rst2 = 1'b0; rst1 = 1'b0;
    @(negedge CLK);
    checks++; if (rdy2 !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b want=1", rdy2); end
    checks++; if (rdy1 !== 1'b1) begin failures++; $display("FAIL reset_release_ready_div1 got=%b want=1", rdy1); end
  endtask

  task automatic test_single();
    sel = 1'b0;
    send(12'hA5C, 12'h3F1, PD_NORMAL);
    capture();
    checks++; if (cap_a !== 16'h0A5C) begin failures++; $display("FAIL single_dina got=%h want=0a5c", cap_a); end
    checks++; if (cap_b !== 16'h03F1) begin failures++; $display("FAIL single_dinb got=%h want=03f1", cap_b); end
    checks++; if (cap_fall != 16) begin failures++; $display("FAIL single_falls got=%0d want=16", cap_fall); end
    checks++; if (cap_low != 64) begin failures++; $display("FAIL single_sync_low got=%0d want=64", cap_low); end
    checks++; if (cap_gap != 4) begin failures++; $display("FAIL single_gap got=%0d want=4", cap_gap); end
    checks++; if (cap_rdy !== 1'b1) begin failures++; $display("FAIL single_idle_ready got=%b want=1", cap_rdy); end
  endtask

  task automatic test_power_down();
    logic [11:0] b;
    sel = 1'b0;
    b = 12'($urandom);
    send(12'h123, b, 2'b11);
    data_a = 12'($urandom); data_b = ~b; pd = 2'b01;
    capture();
    checks++; if (cap_a !== 16'h3123) begin failures++; $display("FAIL pd_dina got=%h want=3123", cap_a); end
    checks++; if (cap_b !== exp_word(2'b11, b)) begin failures++; $display("FAIL pd_dinb got=%h want=%h", cap_b, exp_word(2'b11, b)); end
  endtask

  task automatic test_random();
    logic [11:0] a, b;
    logic [1:0]  p;
    sel = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a = 12'($urandom); b = 12'($urandom); p = 2'($urandom);
      send(a, b, p);
      capture();
      checks++; if (cap_a !== exp_word(p, a)) begin failures++; $display("FAIL random_dina[%0d] got=%h want=%h", k, cap_a, exp_word(p, a)); end
      checks++; if (cap_b !== exp_word(p, b)) begin failures++; $display("FAIL random_dinb[%0d] got=%h want=%h", k, cap_b, exp_word(p, b)); end
    end
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    q_a[0] = 12'h000; q_a[1] = 12'hFFF; q_a[2] = 12'h800;
    for (int k = 0; k < 3; k++) q_b[k] = 12'($urandom);
    run_b2b(3);
    for (int k = 0; k < 3; k++) begin
      checks++; if (r_a[k] !== exp_word(PD_NORMAL, q_a[k])) begin failures++; $display("FAIL b2b_dina[%0d] got=%h want=%h", k, r_a[k], exp_word(PD_NORMAL, q_a[k])); end
      checks++; if (r_b[k] !== exp_word(PD_NORMAL, q_b[k])) begin failures++; $display("FAIL b2b_dinb[%0d] got=%h want=%h", k, r_b[k], exp_word(PD_NORMAL, q_b[k])); end
      checks++; if (r_gap[k] != 4) begin failures++; $display("FAIL b2b_gap[%0d] got=%0d want=4", k, r_gap[k]); end
    end
    for (int k = 1; k < 3; k++) begin
      checks++; if (r_t[k] - r_t[k-1] != 69) begin failures++; $display("FAIL b2b_period[%0d] got=%0d want=69", k, r_t[k] - r_t[k-1]); end
    end
  endtask

  task automatic test_mid_reset();
    logic prev;
    int   nf, w;
    sel = 1'b0;
    send(12'($urandom), 12'($urandom), PD_NORMAL);
    prev = 1'b1; nf = 0; w = 0;
    while (nf < 6 && w < 300) begin
      @(negedge CLK);
      w++;
      if (prev && !sclk2) nf++;
      prev = sclk2;
    end
    checks++; if (nf != 6) begin failures++; $display("FAIL midrst_falls got=%0d want=6", nf); end
    repeat (3) @(negedge CLK);
    checks++; if (sync2 !== 1'b0) begin failures++; $display("FAIL midrst_in_frame got=%b want=0", sync2); end
    #2 rst2 = 1'b1;
    #1;
    checks++; if (sync2 !== 1'b1) begin failures++; $display("FAIL midrst_sync_async got=%b want=1", sync2); end
    checks++; if (sclk2 !== 1'b1) begin failures++; $display("FAIL midrst_sclk_async got=%b want=1", sclk2); end
    checks++; if (dina2 !== 1'b0) begin failures++; $display("FAIL midrst_dina got=%b want=0", dina2); end
    checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b want=0", busy2); end
    repeat (2) @(negedge CLK);
    rst2 = 1'b0;
    #1;
    checks++; if (rdy2 !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b want=1", rdy2); end
    send(12'h7E7, 12'h18C, PD_NORMAL);
    capture();
    checks++; if (cap_a !== 16'h07E7) begin failures++; $display("FAIL midrst_next_dina got=%h want=07e7", cap_a); end
    checks++; if (cap_b !== 16'h018C) begin failures++; $display("FAIL midrst_next_dinb got=%h want=018c", cap_b); end
  endtask

  task automatic test_clkdiv1();
    sel = 1'b1;
    q_a[0] = 12'hFFF; q_b[0] = 12'h001;
    q_a[1] = 12'hFFF; q_b[1] = 12'h001;
    run_b2b(2);
    checks++; if (r_a[0] !== 16'h0FFF) begin failures++; $display("FAIL div1_dina got=%h want=0fff", r_a[0]); end
    checks++; if (r_b[0] !== 16'h0001) begin failures++; $display("FAIL div1_dinb got=%h want=0001", r_b[0]); end
    checks++; if (r_low[0] != 32) begin failures++; $display("FAIL div1_sync_low got=%0d want=32", r_low[0]); end
    checks++; if (r_chg[0] != 31) begin failures++; $display("FAIL div1_sclk_toggles got=%0d want=31", r_chg[0]); end
    checks++; if (r_fall[0] != 16) begin failures++; $display("FAIL div1_falls got=%0d want=16", r_fall[0]); end
    checks++; if (r_gap[0] != 2) begin failures++; $display("FAIL div1_gap got=%0d want=2", r_gap[0]); end
    checks++; if (r_t[1] - r_t[0] != 35) begin failures++; $display("FAIL div1_period got=%0d want=35", r_t[1] - r_t[0]); end
    checks++; if (r_a[1] !== 16'h0FFF || r_b[1] !== 16'h0001) begin failures++; $display("FAIL div1_second_frame got=%h/%h want=0fff/0001", r_a[1], r_b[1]); end
    sel = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_expired time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst2 = 1'b1; rst1 = 1'b1; valid2 = 1'b0; valid1 = 1'b0;
    data_a = '0; data_b = '0; pd = PD_NORMAL;
    test_reset();
    test_single();
    test_power_down();
    test_random();
    test_back_to_back();
    test_mid_reset();
    test_clkdiv1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
